// File: rtl/mem_port0_arbiter_pkg.sv
// rtl/mem_port0_arbiter_pkg.sv - shared FSM state and requester index definitions for the port-0 arbiter
package mem_port0_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU    = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/mem_port0_arbiter.sv
// rtl/mem_port0_arbiter.sv - two-requester arbiter with lock for RAM port 0; MEM_ARB_RR_EN enables round-robin
module mem_port0_arbiter
  import mem_port0_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 7,
  parameter int MEM_DATA_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      r0_valid,
  input  logic                      r0_rnw,
  input  logic [MEM_ADDR_WIDTH-1:0] r0_addr,
  input  logic [MEM_DATA_WIDTH-1:0] r0_wdata,
  input  logic                      r0_lock,
  output logic                      r0_ready,
  output logic                      r0_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] r0_rdata,
  input  logic                      r1_valid,
  input  logic                      r1_rnw,
  input  logic [MEM_ADDR_WIDTH-1:0] r1_addr,
  input  logic [MEM_DATA_WIDTH-1:0] r1_wdata,
  input  logic                      r1_lock,
  output logic                      r1_ready,
  output logic                      r1_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] r1_rdata,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address0,
  output logic [MEM_DATA_WIDTH-1:0] mem_data_in0,
  output logic                      mem_rnw0,
  input  logic [MEM_DATA_WIDTH-1:0] mem_data_out0
);

  arb_state_e state_q, state_d;
  logic       gnt0, gnt1;
  logic       rd_pend0_q, rd_pend1_q;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;
`endif

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (r0_valid && r1_valid) begin
`ifdef MEM_ARB_RR_EN
          if (last_grant_q == REQ_CPU) gnt1 = 1'b1;
          else                         gnt0 = 1'b1;
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = r0_valid;
          gnt1 = r1_valid;
        end
      end
      LOCK0:   gnt0 = r0_valid;
      LOCK1:   gnt1 = r1_valid;
      default: state_d = IDLE;
    endcase
    // The lock bit of the accepted beat alone decides where the FSM goes next
    if (gnt0)      state_d = r0_lock ? LOCK0 : IDLE;
    else if (gnt1) state_d = r1_lock ? LOCK1 : IDLE;
  end

  always_comb begin
    mem_rnw0     = 1'b1;
    mem_address0 = '0;
    mem_data_in0 = '0;
    if (gnt0) begin
      mem_rnw0     = r0_rnw;
      mem_address0 = r0_addr;
      mem_data_in0 = r0_wdata;
    end else if (gnt1) begin
      mem_rnw0     = r1_rnw;
      mem_address0 = r1_addr;
      mem_data_in0 = r1_wdata;
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_pend0_q <= gnt0 && r0_rnw;
      rd_pend1_q <= gnt1 && r1_rnw;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     last_grant_q <= REQ_LOADER;
    else if (gnt0) last_grant_q <= REQ_CPU;
    else if (gnt1) last_grant_q <= REQ_LOADER;
  end
`endif

  // RAM data is only presented to the requester whose read is landing this cycle
  assign r0_rvalid = rd_pend0_q;
  assign r1_rvalid = rd_pend1_q;
  assign r0_rdata  = rd_pend0_q ? mem_data_out0 : '0;
  assign r1_rdata  = rd_pend1_q ? mem_data_out0 : '0;

endmodule

// File: doc/mem_port0_arbiter.md
MEM_PORT0_ARBITER -- requirements
Module: mem_port0_arbiter

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 7, SHALL set the memory address width.
REQ-002 Parameter MEM_DATA_WIDTH, default 8, SHALL set the memory data width.
REQ-003 clock  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 rN_valid  in  1  (N=0,1) SHALL flag a pending request from requester N.
REQ-006 rN_rnw  in  1  SHALL select the access type: 1 = read, 0 = write.
REQ-007 rN_addr  in  MEM_ADDR_WIDTH  SHALL carry the request address.
REQ-008 rN_wdata  in  MEM_DATA_WIDTH  SHALL carry the write data.
REQ-009 rN_lock  in  1  SHALL request that port ownership be kept after this beat.
REQ-010 rN_ready  out  1  SHALL signal that the request is accepted this cycle.
REQ-011 rN_rvalid  out  1  SHALL flag that rN_rdata is valid.
REQ-012 rN_rdata  out  MEM_DATA_WIDTH  SHALL return the read data.
REQ-013 mem_address0, mem_data_in0, mem_rnw0  out  SHALL drive port 0 of the synchronous dual-port RAM.
REQ-014 mem_data_out0  in  MEM_DATA_WIDTH  SHALL carry the RAM port-0 read data, valid one cycle after the address is sampled.

Function
REQ-015 A beat SHALL be accepted when rN_valid && rN_ready are both high; at most one requester SHALL be ready in any cycle.
REQ-016 rN_ready SHALL be combinational from the current state and the rN_valid inputs; it SHALL never be high while rN_valid is low.
REQ-017 The mem_* outputs SHALL be driven combinationally from the accepted requester; with no accepted beat they SHALL be mem_rnw0=1, mem_address0=0 and mem_data_in0=0.
REQ-018 An accepted read SHALL assert rN_rvalid for exactly one cycle, on the following cycle; rN_rdata SHALL equal mem_data_out0 and SHALL read 0 whenever rN_rvalid is low.
REQ-019 An accepted write SHALL produce no rvalid.
REQ-020 FSM states are IDLE, LOCK0 and LOCK1.
REQ-021 In IDLE, a single valid requester SHALL be granted; two simultaneous requesters SHALL be resolved per REQ-029.
REQ-022 An accepted beat with rN_lock=1 SHALL move the FSM to LOCKN; a beat with lock=0 SHALL leave it in or return it to IDLE.
REQ-023 In LOCKN, only requester N SHALL be granted, and the other requester SHALL stall even when valid.
REQ-024 The FSM SHALL leave LOCKN to IDLE on an accepted beat from N with rN_lock=0, and SHALL stay in LOCKN while rN_valid is low.
REQ-025 Back-to-back beats SHALL sustain one access per cycle, including a read followed by a write to the same address.

Reset
REQ-026 Reset SHALL force: state=IDLE, last_grant=1, r0_rvalid=0 and r1_rvalid=0; all rN_rdata outputs SHALL read 0.
REQ-027 A reset asserted mid-lock or with a read in flight SHALL discard that read (no rvalid after release) and SHALL clear the lock.
REQ-028 The first cycle after reset release SHALL be arbitrated normally.

Configuration
REQ-029 With MEM_ARB_RR_EN defined, simultaneous IDLE requests SHALL go to the requester not equal to last_grant, and last_grant SHALL update on every accepted beat. Without it, requester 0 SHALL always win and last_grant SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/LOCK0/LOCK1) and the requester-index constants REQ_CPU=0 and REQ_LOADER=1.
REQ-031 The design SHALL be a single module with no sub-modules; the RAM SHALL be instantiated by the parent alongside this block.

Verification
REQ-032 Write then read: r0 writes 0xA5 to address 0x10, then r0 reads 0x10 -> r0_rvalid is high one cycle later with r0_rdata=0xA5.
REQ-033 Contention with MEM_ARB_RR_EN: both requesters continuously valid for 4 cycles after reset -> grants go 0,1,0,1. Without the macro -> grants go 0,0,0,0.
REQ-034 Lock: r1 makes 3 beats with lock=1,1,0 while r0 is valid -> r0_ready stays 0 for all 3 beats and r0 is granted on the next cycle.
REQ-035 Lock hold: in LOCK1, r1_valid drops for 2 cycles while r0 is valid -> r0 is not granted, and the state stays LOCK1.
REQ-036 Reset mid-read: r0 read accepted, then reset asserted in the next cycle -> r0_rvalid=0 and state=IDLE; after release, an r1 request is granted immediately.
REQ-037 Idle port: no requests -> mem_rnw0=1, mem_address0=0 and both rvalid outputs stay 0.
